// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// half_adder
//   One-bit half adder; two of these plus an OR form the full-add cell used
//   by the serial adder.
//   a, b   : input bits
//   sum    : a XOR b
//   c_out  : a AND b
// -----------------------------------------------------------------------------
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic c_out
);
    assign sum   = a ^ b;
    assign c_out = a & b;
endmodule

// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder: computes A + B + C_IN one bit per clock, LSB
//   first, with a START/BUSY/DONE handshake for the terminal controller.
//
//   CLK       : system clock, rising edge
//   RESET_N   : asynchronous active-low reset
//   START     : launch request, accepted in IDLE or DONE
//   A, B      : operands, captured on an accepted START
//   C_IN      : carry-in, captured on an accepted START
//   BUSY      : high while the addition runs
//   DONE      : one-cycle pulse, result valid and new
//   SUM       : registered sum, held until the next completion
//   C_OUT     : registered carry out of the MSB
//   OVERFLOW  : registered signed overflow (carry into MSB ^ carry out)
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for START
//   RUN    | one operand bit added per edge, LSB first
//   DONE   | result published this cycle; START here chains a new op
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 3
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             C_OUT,
    output logic             OVERFLOW
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sr, b_sr, r_sr;
    logic             carry;
    logic [CNT_W-1:0] bit_cnt;

    logic ha0_sum, ha0_c, ha1_sum, ha1_c;
    logic fa_sum, fa_c_out;
    logic accept, last_bit;

    half_adder u_ha0 (.a(a_sr[0]), .b(b_sr[0]), .sum(ha0_sum), .c_out(ha0_c));
    half_adder u_ha1 (.a(ha0_sum), .b(carry),   .sum(ha1_sum), .c_out(ha1_c));

    assign fa_sum   = ha1_sum;
    assign fa_c_out = ha0_c | ha1_c;

    // DONE accepts START like IDLE so operations can run back-to-back.
    assign accept   = START && ((state == S_IDLE) || (state == S_DONE));
    assign last_bit = (state == S_RUN) && (bit_cnt == LAST_BIT);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (START) state_nxt = S_RUN;
            S_RUN:   if (last_bit) state_nxt = S_DONE;
            S_DONE:  state_nxt = START ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state == S_RUN);
        DONE = (state == S_DONE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            a_sr     <= '0;
            b_sr     <= '0;
            r_sr     <= '0;
            carry    <= 1'b0;
            bit_cnt  <= '0;
            SUM      <= '0;
            C_OUT    <= 1'b0;
            OVERFLOW <= 1'b0;
        end else if (accept) begin
            a_sr    <= A;
            b_sr    <= B;
            carry   <= C_IN;
            bit_cnt <= '0;
        end else if (state == S_RUN) begin
            // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
            r_sr    <= {fa_sum, r_sr[WIDTH-1:1]};
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            carry   <= fa_c_out;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (last_bit) begin
                SUM      <= {fa_sum, r_sr[WIDTH-1:1]};
                C_OUT    <= fa_c_out;
                // carry still holds the carry into the MSB on this edge.
                OVERFLOW <= carry ^ fa_c_out;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
    localparam int W = 3;

    logic         CLK = 1'b0;
    logic         RESET_N;
    logic         START;
    logic [W-1:0] A, B;
    logic         C_IN;
    logic         BUSY, DONE, C_OUT, OVERFLOW;
    logic [W-1:0] SUM;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           done_cyc;
    } exp_t;

    exp_t exp_q[$];

    serial_adder #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .A(A), .B(B), .C_IN(C_IN),
        .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .C_OUT(C_OUT), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model; called at the negedge where START is presented, so the
    // accepting edge is cyc+1 and DONE is visible at negedge cyc+1+W.
    task automatic push_exp(input int a, input int b, input int cin);
        exp_t e;
        int   tot, sa, sb, ss;
        tot = a + b + cin;
        sa  = (a >= 4) ? a - 8 : a;
        sb  = (b >= 4) ? b - 8 : b;
        ss  = sa + sb + cin;
        e.sum      = W'(tot % 8);
        e.cout     = (tot >= 8);
        e.ovf      = (ss > 3) || (ss < -4);
        e.done_cyc = cyc + 1 + W;
        exp_q.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (RESET_N === 1'b1 && DONE === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum", int'(SUM), int'(e.sum));
                check("c_out", int'(C_OUT), int'(e.cout));
                check("overflow", int'(OVERFLOW), int'(e.ovf));
                check("done_latency", cyc, e.done_cyc);
            end
        end
    end

    // Called at a negedge; returns after the result has been collected.
    task automatic run_op(input int a, input int b, input int cin, output int busy_cycles);
        A = W'(a); B = W'(b); C_IN = cin[0]; START = 1'b1;
        push_exp(a, b, cin);
        @(negedge CLK);
        START = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            if (BUSY) busy_cycles++;
            if (!BUSY && exp_q.size() == 0) break;
            @(negedge CLK);
        end
        if (exp_q.size() != 0) begin
            check("op_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        int bc, t;
        RESET_N = 1'b0; START = 1'b0; A = '0; B = '0; C_IN = 1'b0;
        #2;
        check("rst_busy", int'(BUSY), 0);
        check("rst_done", int'(DONE), 0);
        check("rst_sum", int'(SUM), 0);
        check("rst_cout", int'(C_OUT), 0);
        check("rst_ovf", int'(OVERFLOW), 0);

        // Release and issue on the same negedge: first edge must accept.
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        run_op(3, 1, 0, bc);
        check("busy_cycles", bc, 3);

        run_op(7, 7, 1, bc);
        run_op(4, 4, 0, bc);

        // START held through RUN with changed operands.
        @(negedge CLK);
        t = cyc;
        A = 3'd2; B = 3'd1; C_IN = 1'b0; START = 1'b1;
        push_exp(2, 1, 0);
        @(negedge CLK);
        A = 3'd5; B = 3'd5;
        check("busy_after_start", int'(BUSY), 1);
        for (int i = 0; i < 10 && cyc < t + 4; i++) @(negedge CLK);
        check("done_in_held", int'(DONE), 1);
        push_exp(5, 5, 0);
        @(negedge CLK);
        @(negedge CLK);
        check("held_sum_mid_run", int'(SUM), 3);
        START = 1'b0;
        @(negedge CLK);
        check("held_sum_late_run", int'(SUM), 3);
        for (int i = 0; i < 12 && exp_q.size() != 0; i++) @(negedge CLK);
        check("held_pending", exp_q.size(), 0);
        exp_q.delete();
        @(negedge CLK);

        // Reset mid-operation, asserted asynchronously between edges.
        A = 3'd6; B = 3'd1; C_IN = 1'b0; START = 1'b1;
        push_exp(6, 1, 0);
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        @(posedge CLK);
        #2;
        RESET_N = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_busy", int'(BUSY), 0);
        check("midrst_done", int'(DONE), 0);
        check("midrst_sum", int'(SUM), 0);
        check("midrst_cout", int'(C_OUT), 0);
        check("midrst_ovf", int'(OVERFLOW), 0);
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int i = 0; i < 8; i++) @(negedge CLK);
        check("idle_after_rst", int'(BUSY), 0);
        check("sum_after_rst", int'(SUM), 0);
        run_op(1, 1, 0, bc);
        check("busy_cycles_post_rst", bc, 3);

        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                for (int c = 0; c < 2; c++)
                    run_op(a, b, c, bc);

        repeat (3) @(negedge CLK);
        check("final_pending", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
